counter_gen: RTL and testbench



---
 rtl/counter_gen.sv | 99 +++++++++
 tb/tb_counter_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_gen.sv
// Parametrised up/down counter with prescaler, load, wrap/saturate and status.
// Ports: clk, rst (sync, active-high), en, up, load, load_val -> cnt, tc, wrap.
module counter_gen #(
  parameter int WIDTH    = 8,
  parameter int MAX      = 2**WIDTH-1,
  parameter int SAT      = 0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(1);

  logic             tick;
  logic [WIDTH:0]   inc;
  logic [WIDTH:0]   dec;
  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] cnt_nxt;
  logic             wrap_nxt;

  // One extra bit: top compare is exact, borrow flags zero.
  assign inc    = {1'b0, cnt} + ONE_X;
  assign dec    = {1'b0, cnt} - ONE_X;
  assign at_top = inc > MAX_X;
  assign at_bot = dec[WIDTH];

  assign ld_val = (load_val > MAX_V) ? MAX_V : load_val;

  assign tc = up ? (cnt == MAX_V) : (cnt == '0);

  // rst/load override the prescaler inside its own register.
  if (PRESCALE > 1) begin : g_pre
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE-1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] pre;

    assign tick = en && (pre == LAST);

    always_ff @(posedge clk) begin
      if (rst || load) begin
        pre <= '0;
      end else if (en) begin
        pre <= tick ? '0 : pre + ONE;
      end
    end
  end else begin : g_nopre
    assign tick = en;
  end

  always_comb begin
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    if (tick) begin
      if (up) begin
        if (!at_top) begin
          cnt_nxt = inc[WIDTH-1:0];
        end else if (SAT == 0) begin
          cnt_nxt  = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (!at_bot) begin
          cnt_nxt = dec[WIDTH-1:0];
        end else if (SAT == 0) begin
          cnt_nxt  = MAX_V;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      cnt  <= ld_val;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_counter_gen.sv
// Bench for counter_gen: four configurations share one stimulus stream
// and are each compared against an arithmetic reference model.
module tb_counter_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [7:0] lv = '0;

  logic [7:0] c0;
  logic [3:0] c1;
  logic [3:0] c2;
  logic [7:0] c3;
  logic       t0, t1, t2, t3;
  logic       w0, w1, w2, w3;

  int n_cmp = 0;
  int n_err = 0;

  localparam int MX[4] = '{255, 9, 9, 255};
  localparam int SA[4] = '{0, 0, 1, 0};
  localparam int PS[4] = '{1, 1, 1, 3};
  localparam int LM[4] = '{255, 15, 15, 255};

  int mc[4];
  int mp[4];
  int mw[4];

  always #5 clk = ~clk;

  counter_gen #(.WIDTH(8)) u0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(lv), .cnt(c0), .tc(t0), .wrap(w0)
  );

  counter_gen #(.WIDTH(4), .MAX(9), .SAT(0)) u1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(lv[3:0]), .cnt(c1), .tc(t1), .wrap(w1)
  );

  counter_gen #(.WIDTH(4), .MAX(9), .SAT(1)) u2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(lv[3:0]), .cnt(c2), .tc(t2), .wrap(w2)
  );

  counter_gen #(.WIDTH(8), .PRESCALE(3)) u3 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(lv), .cnt(c3), .tc(t3), .wrap(w3)
  );

  task automatic cmp(input string tag, input logic [31:0] obs,
                     input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_cnt(input int k);
    case (k)
      0: return 32'(c0);
      1: return 32'(c1);
      2: return 32'(c2);
      default: return 32'(c3);
    endcase
  endfunction

  function automatic logic [31:0] obs_tc(input int k);
    case (k)
      0: return 32'(t0);
      1: return 32'(t1);
      2: return 32'(t2);
      default: return 32'(t3);
    endcase
  endfunction

  function automatic logic [31:0] obs_wrap(input int k);
    case (k)
      0: return 32'(w0);
      1: return 32'(w1);
      2: return 32'(w2);
      default: return 32'(w3);
    endcase
  endfunction

  function automatic int mtc(input int k);
    return up ? int'(mc[k] == MX[k]) : int'(mc[k] == 0);
  endfunction

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      cmp($sformatf("cnt%0d", k), obs_cnt(k), mc[k]);
      cmp($sformatf("wrap%0d", k), obs_wrap(k), mw[k]);
      cmp($sformatf("tc%0d", k), obs_tc(k), mtc(k));
    end
  endtask

  task automatic model_step();
    int v;
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        mc[k] = 0; mp[k] = 0; mw[k] = 0;
      end else if (load) begin
        v = int'(lv) & LM[k];
        mc[k] = (v > MX[k]) ? MX[k] : v;
        mp[k] = 0; mw[k] = 0;
      end else if (en) begin
        mw[k] = 0;
        if (mp[k] == PS[k] - 1) begin
          mp[k] = 0;
          if (up) begin
            if (mc[k] < MX[k]) mc[k] = mc[k] + 1;
            else if (SA[k] == 0) begin mc[k] = 0; mw[k] = 1; end
          end else begin
            if (mc[k] > 0) mc[k] = mc[k] - 1;
            else if (SA[k] == 0) begin mc[k] = MX[k]; mw[k] = 1; end
          end
        end else begin
          mp[k] = mp[k] + 1;
        end
      end else begin
        mw[k] = 0;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic u,
                     input logic l, input int v);
    rst = r; en = e; up = u; load = l; lv = 8'(v);
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      mc[k] = 0; mp[k] = 0; mw[k] = 0;
    end
    #2;

    // Reset for two cycles, counting up.
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cmp("rst_cnt", 32'(c0), 0);
    cmp("rst_wrap", 32'(w0), 0);
    cmp("rst_tc_up", 32'(t0), 0);

    // Free count to terminal, then wrap.
    for (int i = 0; i < 255; i++) cyc(0, 1, 1, 0, 0);
    cmp("free_255", 32'(c0), 255);
    cmp("free_tc", 32'(t0), 1);
    cyc(0, 1, 1, 0, 0);
    cmp("free_wrap_cnt", 32'(c0), 0);
    cmp("free_wrap", 32'(w0), 1);
    cyc(0, 1, 1, 0, 0);
    cmp("free_wrap_once", 32'(w0), 0);

    // Decade wrap.
    cyc(0, 0, 1, 1, 7);
    cmp("dec_load", 32'(c1), 7);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cmp("dec_9", 32'(c1), 9);
    cmp("dec_tc9", 32'(t1), 1);
    cyc(0, 1, 1, 0, 0);
    cmp("dec_0", 32'(c1), 0);
    cmp("dec_wrap", 32'(w1), 1);
    cyc(0, 1, 1, 0, 0);
    cmp("dec_1", 32'(c1), 1);

    // Saturating count down and load clamp.
    cyc(0, 0, 0, 1, 2);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
    cmp("sat_hold0", 32'(c2), 0);
    cmp("sat_nowrap", 32'(w2), 0);
    cyc(0, 0, 1, 1, 15);
    cmp("clamp", 32'(c2), 9);

    // Prescaler, including an en gap.
    cyc(1, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0, 0);
    cmp("pre_3", 32'(c3), 3);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cmp("pre_gap_hold", 32'(c3), 3);
    cyc(0, 1, 1, 0, 0);
    cmp("pre_gap_step", 32'(c3), 4);

    // Priority.
    cyc(0, 0, 1, 1, 255);
    cyc(0, 1, 1, 1, 5);
    cmp("prio_load", 32'(c0), 5);
    cmp("prio_nowrap", 32'(w0), 0);
    cyc(1, 1, 1, 1, 7);
    cmp("prio_rst", 32'(c0), 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cmp("rst_pre_hold", 32'(c3), 0);
    cyc(0, 1, 1, 0, 0);
    cmp("rst_pre_step", 32'(c3), 1);

    // Direction change.
    cyc(0, 0, 0, 1, 1);
    cyc(0, 1, 0, 0, 0);
    cmp("dir_0", 32'(c1), 0);
    cyc(0, 1, 0, 0, 0);
    cmp("dir_9", 32'(c1), 9);
    cmp("dir_wrap", 32'(w1), 1);
    cmp("dir_tc_dn", 32'(t1), 0);
    en = 1'b0;
    up = 1'b1;
    #1;
    cmp("dir_tc_up", 32'(t1), 1);
    cyc(0, 1, 1, 0, 0);
    cmp("dir_wrap_up", 32'(c1), 0);
    cmp("dir_wrap_up_w", 32'(w1), 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(logic'($urandom_range(0, 99) == 0),
          logic'($urandom_range(0, 9) < 7),
          logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 9) == 0),
          int'($urandom_range(0, 255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
